// File: rtl/serial_word_tx.sv
// serial_word_tx
// Parallel-in, serial-out transmitter. A SIZE-bit word is accepted on a
// valid/ready handshake and emitted one bit per cycle in which pace is high.
// The sd/sen pair feeds the serial-in side of a shift-register lane directly
// (sd -> d, sen -> en, dir held 0), so the receiver shifts in on the same
// rising edge that the transmitter advances.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   load_data      word to transmit
//   load_lsb_first bit order for this word (0 = MSB first, 1 = LSB first)
//   load_valid     word offered
//   load_ready     block can accept a word (IDLE and not in reset)
//   pace           bit-enable; one bit leaves per paced cycle while shifting
//   sd             serial data bit
//   sen            serial strobe, receiver samples sd on the same edge
//   last           high together with the final bit's strobe
//   busy           word in flight (SHIFT or DONE)
//   done           one-cycle pulse after the final bit
module serial_word_tx #(
    parameter int SIZE = 8,
    localparam int CW = $clog2(SIZE + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] load_data,
    input  logic            load_lsb_first,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic            pace,
    output logic            sd,
    output logic            sen,
    output logic            last,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] shreg_q, shreg_d;
    logic [CW-1:0]   count_q, count_d;
    logic            lsb_q, lsb_d;

    logic in_shift;

    // Next-state logic. The shift register always moves toward the bit that
    // is currently presented on sd, so the output tap stays fixed per word.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        lsb_d   = lsb_q;
        case (state_q)
            ST_IDLE: begin
                // load_ready is high whenever IDLE is observed at an edge
                if (load_valid) begin
                    shreg_d = load_data;
                    lsb_d   = load_lsb_first;
                    count_d = CW'(SIZE);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // pace low holds everything, so a stall neither drops nor
                // repeats a bit
                if (pace) begin
                    if (lsb_q) begin
                        shreg_d = {1'b0, shreg_q[SIZE-1:1]};
                    end else begin
                        shreg_d = {shreg_q[SIZE-2:0], 1'b0};
                    end
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            count_q <= '0;
            lsb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
            lsb_q   <= lsb_d;
        end
    end

    // Outputs are decoded straight from the state flops; only sen (and last,
    // which depends on it) follows pace combinationally, so the receiver
    // sees the strobe in the very cycle the transmitter advances.
    assign in_shift   = (state_q == ST_SHIFT);
    // Reset holds the FSM in IDLE, so ready is masked by rst explicitly.
    assign load_ready = (state_q == ST_IDLE) & ~rst;
    assign sd         = in_shift & (lsb_q ? shreg_q[0] : shreg_q[SIZE-1]);
    assign sen        = in_shift & pace;
    assign last       = sen & (count_q == CW'(1));
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_word_tx.sv
module tb_serial_word_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_lsb_first = 1'b0;
    logic       load_valid = 1'b0;
    logic       pace = 1'b0;
    logic       load_ready, sd, sen, last, busy, done;

    serial_word_tx #(.SIZE(8)) dut (
        .clk(clk),
        .rst(rst),
        .load_data(load_data),
        .load_lsb_first(load_lsb_first),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .pace(pace),
        .sd(sd),
        .sen(sen),
        .last(last),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Index of the rising edge that ends the current cycle.
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int tests = 0;
    int fails = 0;

    // Receiver model: shift register with d=sd, en=sen, dir=0.
    logic [7:0] rx = 8'h00;
    int strobes = 0;
    int word_bits = 0;
    int last_bad = 0;
    int bad_strobe = 0;
    int stall_err = 0;
    int done_cnt = 0;
    int done_edge = -1;
    int last_strobe_edge = -1;
    int hs_cnt = 0;
    int hs_edge = -1;
    logic prev_shift = 1'b0;
    logic prev_pace = 1'b0;
    logic prev_sd = 1'b0;

    int pace_pat [20] = '{1,0,0,1,0,1,0,0,1,1,0,1,0,0,0,1,0,1,1,0};

    // One clock cycle: drive inputs at the falling edge, observe 1 ns later.
    task automatic step(input logic pv, input logic vv, input logic [7:0] dv, input logic lv);
        @(negedge clk);
        pace = pv;
        load_valid = vv;
        load_data = dv;
        load_lsb_first = lv;
        #1;
        if (rst) begin
            word_bits = 0;
            prev_shift = 1'b0;
        end else begin
            if (sen && !(busy && !done)) bad_strobe++;
            if (prev_shift && !prev_pace && busy && !done && sd !== prev_sd) stall_err++;
            if (sen) begin
                rx = {rx[6:0], sd};
                strobes++;
                word_bits++;
                last_strobe_edge = edge_n;
                if (last !== (word_bits == 8)) last_bad++;
            end else if (last) begin
                last_bad++;
            end
            if (done) begin
                done_cnt++;
                done_edge = edge_n;
                word_bits = 0;
            end
            if (vv && load_ready) begin
                hs_cnt++;
                hs_edge = edge_n;
            end
            prev_shift = busy && !done;
            prev_pace = pv;
            prev_sd = sd;
        end
    endtask

    // Offer a word with pace high until it is taken; h = handshake edge.
    task automatic offer(input logic [7:0] d, input logic lsb, output int h);
        int h0;
        h0 = hs_cnt;
        h = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, d, lsb);
            if (hs_cnt != h0) begin
                h = hs_edge;
                break;
            end
        end
        tests++;
        if (h < 0) begin
            fails++;
            $display("FAIL offer_timeout: got no handshake, required one within 20 cycles");
        end
    endtask

    // Run the word out until load_ready returns; optionally pulse load_valid
    // at edge inj_edge. ready_edge = edge ending the first ready cycle.
    task automatic drain(input int paced, input int inj_edge, output int ready_edge);
        logic pv;
        ready_edge = -1;
        for (int k = 0; k < 80; k++) begin
            pv = (paced != 0 && k < 20) ? (pace_pat[k] != 0) : 1'b1;
            step(pv, (edge_n + 1 == inj_edge), 8'h00, 1'b0);
            if (load_ready) begin
                ready_edge = edge_n;
                break;
            end
        end
        tests++;
        if (ready_edge < 0) begin
            fails++;
            $display("FAIL drain_timeout: load_ready never returned within 80 cycles");
        end
        $display("[TB] word complete rx=%02h strobes=%0d ready_edge=%0d", rx, strobes, ready_edge);
    endtask

    task automatic test_reset;
        load_valid = 1'b1;
        pace = 1'b1;
        load_data = 8'hFF;
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({load_ready, sd, sen, last, busy, done} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 000000", {load_ready, sd, sen, last, busy, done});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if ({load_ready, sd, sen, last, busy, done} !== 6'b0) begin
            fails++;
            $display("FAIL reset_held: got %b required 000000", {load_ready, sd, sen, last, busy, done});
        end
        @(negedge clk);
        load_valid = 1'b0;
        rst = 1'b0;
        #1;
        tests++;
        if (load_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got ready=%b busy=%b required ready=1 busy=0", load_ready, busy);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_msb_first;
        int s, d, h, r;
        s = strobes;
        d = done_cnt;
        offer(8'hC1, 1'b0, h);
        drain(0, -1, r);
        tests++;
        if (rx !== 8'hC1) begin fails++; $display("FAIL msb_rx: got %02h required c1", rx); end
        tests++;
        if (strobes - s != 8) begin fails++; $display("FAIL msb_strobes: got %0d required 8", strobes - s); end
        tests++;
        if (last_strobe_edge != h + 8) begin fails++; $display("FAIL msb_last_edge: got %0d required %0d", last_strobe_edge, h + 8); end
        tests++;
        if (done_edge != h + 9 || done_cnt - d != 1) begin
            fails++;
            $display("FAIL msb_done: got edge %0d count %0d required edge %0d count 1", done_edge, done_cnt - d, h + 9);
        end
        tests++;
        if (r != h + 10) begin fails++; $display("FAIL msb_ready_return: got %0d required %0d", r, h + 10); end
        tests++;
        if (last_bad != 0 || bad_strobe != 0) begin
            fails++;
            $display("FAIL msb_last_strobe: got last_bad=%0d bad_strobe=%0d required 0 0", last_bad, bad_strobe);
        end
    endtask

    task automatic test_lsb_first;
        int s, h, r;
        s = strobes;
        offer(8'hC1, 1'b1, h);
        drain(0, -1, r);
        tests++;
        if (rx !== 8'h83) begin fails++; $display("FAIL lsb_rx: got %02h required 83", rx); end
        tests++;
        if (strobes - s != 8) begin fails++; $display("FAIL lsb_strobes: got %0d required 8", strobes - s); end
        tests++;
        if (r != h + 10) begin fails++; $display("FAIL lsb_ready_return: got %0d required %0d", r, h + 10); end
    endtask

    task automatic test_paced;
        int s, h, r;
        s = strobes;
        offer(8'h5A, 1'b0, h);
        drain(1, -1, r);
        tests++;
        if (rx !== 8'h5A) begin fails++; $display("FAIL paced_rx: got %02h required 5a", rx); end
        tests++;
        if (strobes - s != 8) begin fails++; $display("FAIL paced_strobes: got %0d required 8", strobes - s); end
        tests++;
        if (stall_err != 0) begin fails++; $display("FAIL paced_stall_stable: got %0d changes required 0", stall_err); end
        // Eighth high entry of the pace pattern is index 17 -> edge h+18.
        tests++;
        if (last_strobe_edge != h + 18) begin fails++; $display("FAIL paced_last_edge: got %0d required %0d", last_strobe_edge, h + 18); end
        tests++;
        if (done_edge != h + 19) begin fails++; $display("FAIL paced_done_edge: got %0d required %0d", done_edge, h + 19); end
        tests++;
        if (last_bad != 0) begin fails++; $display("FAIL paced_last: got %0d bad required 0", last_bad); end
    endtask

    task automatic test_back_to_back;
        int s, d, hc0, h1, h2, r;
        logic [7:0] dv;
        s = strobes;
        d = done_cnt;
        hc0 = hs_cnt;
        offer(8'h01, 1'b0, h1);
        for (int i = 0; i < 30; i++) begin
            dv = (edge_n + 1 >= h1 + 9) ? 8'hFF : 8'h01;
            step(1'b1, 1'b1, dv, 1'b0);
            if (edge_n == h1 + 9) begin
                tests++;
                if (rx !== 8'h01) begin fails++; $display("FAIL b2b_first_rx: got %02h required 01", rx); end
            end
            if (hs_cnt == hc0 + 2) break;
        end
        h2 = hs_edge;
        drain(0, -1, r);
        tests++;
        if (hs_cnt - hc0 != 2 || h2 - h1 != 10) begin
            fails++;
            $display("FAIL b2b_handshake: got %0d handshakes spacing %0d required 2 spacing 10", hs_cnt - hc0, h2 - h1);
        end
        tests++;
        if (rx !== 8'hFF) begin fails++; $display("FAIL b2b_second_rx: got %02h required ff", rx); end
        tests++;
        if (strobes - s != 16 || done_cnt - d != 2) begin
            fails++;
            $display("FAIL b2b_counts: got strobes=%0d dones=%0d required 16 2", strobes - s, done_cnt - d);
        end
        tests++;
        if (bad_strobe != 0) begin fails++; $display("FAIL b2b_idle_strobe: got %0d required 0", bad_strobe); end
    endtask

    task automatic test_busy_reject;
        int s, hc0, h, r;
        s = strobes;
        hc0 = hs_cnt;
        offer(8'hAA, 1'b0, h);
        drain(0, h + 3, r);
        tests++;
        if (rx !== 8'hAA) begin fails++; $display("FAIL busy_rx: got %02h required aa", rx); end
        tests++;
        if (hs_cnt - hc0 != 1 || strobes - s != 8) begin
            fails++;
            $display("FAIL busy_ignored: got handshakes=%0d strobes=%0d required 1 8", hs_cnt - hc0, strobes - s);
        end
    endtask

    task automatic test_reset_mid;
        int s, d, h, r;
        s = strobes;
        d = done_cnt;
        offer(8'hF0, 1'b0, h);
        repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        pace = 1'b1;
        #1;
        tests++;
        if (sen !== 1'b1) begin fails++; $display("FAIL rstmid_pending: got sen=%b required 1", sen); end
        rst = 1'b1;
        #1;
        tests++;
        if ({sen, last, done, busy, load_ready} !== 5'b0) begin
            fails++;
            $display("FAIL rstmid_drop: got %b required 00000", {sen, last, done, busy, load_ready});
        end
        tests++;
        if (strobes - s != 3) begin fails++; $display("FAIL rstmid_strobes: got %0d required 3", strobes - s); end
        repeat (2) step(1'b1, 1'b1, 8'h55, 1'b0);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rstmid_hold: got busy=%b done=%b required 0 0", busy, done); end
        @(negedge clk);
        load_valid = 1'b0;
        rst = 1'b0;
        #1;
        tests++;
        if (load_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b required 1", load_ready); end
        s = strobes;
        offer(8'h3C, 1'b0, h);
        drain(0, -1, r);
        tests++;
        if (done_cnt - d != 1) begin fails++; $display("FAIL rstmid_no_done: got %0d dones required 1", done_cnt - d); end
        tests++;
        if (rx !== 8'h3C || strobes - s != 8) begin
            fails++;
            $display("FAIL rstmid_fresh: got rx=%02h strobes=%0d required 3c 8", rx, strobes - s);
        end
    endtask

    initial begin
        test_reset;
        test_msb_first;
        test_lsb_first;
        test_paced;
        test_back_to_back;
        test_busy_reject;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-in, serial-out transmitter. Accepts a SIZE-bit word on a valid/ready handshake and emits it one bit per paced cycle.
- Output is a data bit plus enable strobe. It drives the serial-in side of the stack's shift-register lane directly: sd to d, sen to en, dir held 0.
- Bit order is selected per word: MSB-first (receiver reconstructs the word in order) or LSB-first.
- Sits between the operand/result path and serial stack storage.

Parameters:
SIZE, 8, word width in bits; legal range SIZE >= 2
CW, $clog2(SIZE+1), bit-counter width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
load_data  input  SIZE  word to transmit
load_lsb_first  input  1  bit order for this word, sampled with the handshake: 0 = MSB first, 1 = LSB first
load_valid  input  1  word offered
load_ready  output  1  block can accept a word
pace  input  1  bit-enable; one bit is emitted per cycle with pace=1 while shifting
sd  output  1  serial data bit
sen  output  1  serial strobe; receiver samples sd on the same rising edge
last  output  1  high with the final bit's strobe
busy  output  1  word in flight (SHIFT or DONE)
done  output  1  one-cycle pulse after the final bit

Behaviour:
- Clock and reset are decided: one clock, clk; reset rst is asynchronous and active-high.
- While rst=1:
  - state=IDLE, shift register=0, count=0, order flag=0.
  - load_ready=0, sd=0, sen=0, last=0, busy=0, done=0.
- After rst deasserts, load_ready=1 in the same cycle.
- States:
  - IDLE: load_ready=1, busy=0. On load_valid & load_ready at an edge, capture load_data, capture load_lsb_first, set count=SIZE, go to SHIFT.
  - SHIFT: load_ready=0, busy=1.
    - sd = shreg[SIZE-1] if MSB-first, shreg[0] if LSB-first. Combinational from registers, stable for the whole cycle.
    - sen = pace, combinational.
    - On an edge with pace=1: shift toward the output bit (MSB-first: left, zero fill at bit 0; LSB-first: right, zero fill at MSB) and decrement count.
    - last = sen & (count==1).
    - On an edge with pace=1 and count==1: go to DONE.
    - On an edge with pace=0: hold everything; no bit is lost or duplicated.
  - DONE: done=1, busy=1, load_ready=0, sen=0, sd=0. Next edge goes to IDLE unconditionally.
- Latency with pace held 1:
  - Handshake at edge 0.
  - Bits strobed at edges 1..SIZE.
  - done high in cycle SIZE+1.
  - load_ready high again in cycle SIZE+2.
  - Minimum word-to-word period is SIZE+2 cycles.
- sd=0 and sen=0 in IDLE and DONE regardless of pace.
- load_valid outside IDLE is ignored. load_data and load_lsb_first may change freely after the handshake edge.
- Exactly SIZE strobes are produced per accepted word, never more or fewer.
- Reset mid-word aborts immediately: no further strobes, no done pulse, and the partial word is discarded.
- pace=1 in IDLE or DONE has no effect.

Test Plan:
- MSB-first, SIZE=8, load 0xC1, pace=1 constant:
  - sd on the strobes is 1,1,0,0,0,0,0,1; last is high on the 8th strobe only; done is high in cycle 9; load_ready returns in cycle 10.
  - A shift register receiving d=sd, en=sen, dir=0 holds 0xC1.
- LSB-first, load 0xC1, pace=1:
  - sd on the strobes is 1,0,0,0,0,0,1,1.
  - The same receiver holds 0x83.
- MSB-first, load 0x5A, pace pattern 1,0,0,1,0,1,... (random, about 40% high):
  - Exactly 8 strobes occur; the receiver ends at 0x5A; sd is stable across every pace=0 stall.
  - last coincides with the 8th strobe; done follows one cycle after it.
- Back-to-back traffic: load_valid held high with 0x01, then 0xFF offered at the done cycle:
  - Second handshake occurs at the first IDLE cycle, SIZE+2 after the first.
  - The second word is transmitted intact; no strobes occur in DONE or IDLE.
- Busy rejection: pulse load_valid with 0x00 during SHIFT of word 0xAA:
  - Ignored; the transmitted stream stays 0xAA.
- Reset mid-word: assert rst asynchronously after the 3rd strobe of 0xF0:
  - sen, last, done and busy drop immediately, with no done pulse.
  - After release, load_ready=1, and a fresh load of 0x3C transmits correctly.
